// File: rtl/mac_tx.sv
// GMII-style transmit MAC: preamble/SFD, Ethernet II header, payload, CRC-32 FCS, IPG.
// Optional MAC_TX_PAD_EN: zero-pad short payloads to MIN_PAYLOAD before the FCS.
module mac_tx #(
    parameter logic [7:0] PREAMBLE_BYTE = 8'h55,
    parameter logic [7:0] SFD_BYTE      = 8'hD5,
    parameter int         MIN_PAYLOAD   = 46,
    parameter int         MAX_PAYLOAD   = 1500,
    parameter int         IPG_BYTES     = 12
) (
    input  logic        in_txc,
    input  logic        in_rst_n,
    input  logic        in_start,
    input  logic [47:0] in_dest_mac,
    input  logic [47:0] in_src_mac,
    input  logic [15:0] in_ether_type,
    input  logic [7:0]  in_data,
    input  logic        in_data_valid,
    input  logic        in_data_last,
    output logic        out_data_ready,
    output logic        out_busy,
    output logic        out_txen,
    output logic [7:0]  out_txd,
    output logic        out_txer
);

    localparam logic [10:0] MIN_CNT = 11'(MIN_PAYLOAD);
    localparam logic [10:0] MAX_CNT = 11'(MAX_PAYLOAD);
    localparam logic [10:0] IPG_CNT = 11'(IPG_BYTES - 1);

    typedef enum logic [3:0] {
        S_IDLE, S_PREAMBLE, S_SFD, S_MACDEST, S_MACSRC, S_ETHERTYPE, S_PAYLOAD,
`ifdef MAC_TX_PAD_EN
        S_PAD,
`endif
        S_FCS, S_IPG
    } state_t;

    state_t      state_q, state_d;
    logic [10:0] count_q, count_d;
    logic [47:0] dest_q, dest_d, src_q, src_d;
    logic [15:0] type_q, type_d;
    logic [31:0] crc_q, crc_d;
    logic        txen_q, txen_d, txer_q, txer_d, busy_q, busy_d, over_q, over_d;
    logic [7:0]  txd_q, txd_d;
`ifdef MAC_TX_PAD_EN
    logic [10:0] len_q, len_d;
`endif

    function automatic logic [31:0] crc_next(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    assign out_data_ready = (state_q == S_PAYLOAD) && (count_q < MAX_CNT);

    always_comb begin
        state_d = state_q;
        count_d = count_q + 11'd1;
        dest_d  = dest_q;
        src_d   = src_q;
        type_d  = type_q;
        crc_d   = crc_q;
        busy_d  = busy_q;
        over_d  = over_q;
        txen_d  = 1'b0;
        txd_d   = 8'h00;
        txer_d  = 1'b0;
`ifdef MAC_TX_PAD_EN
        len_d   = len_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (in_start) begin
                    dest_d  = in_dest_mac;
                    src_d   = in_src_mac;
                    type_d  = in_ether_type;
                    crc_d   = '1;
                    over_d  = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_PREAMBLE;
                end
            end
            S_PREAMBLE: begin
                txen_d = 1'b1;
                txd_d  = PREAMBLE_BYTE;
                if (count_q == 11'd6) state_d = S_SFD;
            end
            S_SFD: begin
                txen_d  = 1'b1;
                txd_d   = SFD_BYTE;
                state_d = S_MACDEST;
            end
            // Header fields shift out MSB-first; the captured copies are consumed.
            S_MACDEST: begin
                txen_d = 1'b1;
                txd_d  = dest_q[47:40];
                dest_d = dest_q << 8;
                crc_d  = crc_next(crc_q, dest_q[47:40]);
                if (count_q == 11'd5) state_d = S_MACSRC;
            end
            S_MACSRC: begin
                txen_d = 1'b1;
                txd_d  = src_q[47:40];
                src_d  = src_q << 8;
                crc_d  = crc_next(crc_q, src_q[47:40]);
                if (count_q == 11'd5) state_d = S_ETHERTYPE;
            end
            S_ETHERTYPE: begin
                txen_d = 1'b1;
                txd_d  = type_q[15:8];
                type_d = type_q << 8;
                crc_d  = crc_next(crc_q, type_q[15:8]);
                if (count_q == 11'd1) state_d = S_PAYLOAD;
            end
            S_PAYLOAD: begin
                txen_d = 1'b1;
                if (in_data_valid && out_data_ready) begin
                    txd_d = in_data;
                    crc_d = crc_next(crc_q, in_data);
                    if (in_data_last) begin
`ifdef MAC_TX_PAD_EN
                        if (count_q + 11'd1 < MIN_CNT) begin
                            len_d   = count_q + 11'd1;
                            state_d = S_PAD;
                        end else begin
                            state_d = S_FCS;
                        end
`else
                        state_d = S_FCS;
`endif
                    end else if (count_q + 11'd1 == MAX_CNT) begin
                        over_d  = 1'b1;
                        state_d = S_FCS;
                    end
                end else begin
                    // Underrun: flag one errored byte and abandon the frame without FCS.
                    txer_d  = 1'b1;
                    state_d = S_IPG;
                end
            end
`ifdef MAC_TX_PAD_EN
            S_PAD: begin
                txen_d = 1'b1;
                crc_d  = crc_next(crc_q, 8'h00);
                if (len_q + count_q + 11'd1 == MIN_CNT) state_d = S_FCS;
            end
`endif
            S_FCS: begin
                txen_d = 1'b1;
                txer_d = over_q;
                case (count_q[1:0])
                    2'd0:    txd_d = ~crc_q[7:0];
                    2'd1:    txd_d = ~crc_q[15:8];
                    2'd2:    txd_d = ~crc_q[23:16];
                    default: txd_d = ~crc_q[31:24];
                endcase
                if (count_q == 11'd3) state_d = S_IPG;
            end
            S_IPG: begin
                if (count_q == IPG_CNT) begin
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (state_d != state_q) count_d = '0;
    end

    always_ff @(posedge in_txc) begin
        if (!in_rst_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            dest_q  <= '0;
            src_q   <= '0;
            type_q  <= '0;
            crc_q   <= '1;
            busy_q  <= 1'b0;
            over_q  <= 1'b0;
            txen_q  <= 1'b0;
            txd_q   <= 8'h00;
            txer_q  <= 1'b0;
`ifdef MAC_TX_PAD_EN
            len_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            dest_q  <= dest_d;
            src_q   <= src_d;
            type_q  <= type_d;
            crc_q   <= crc_d;
            busy_q  <= busy_d;
            over_q  <= over_d;
            txen_q  <= txen_d;
            txd_q   <= txd_d;
            txer_q  <= txer_d;
`ifdef MAC_TX_PAD_EN
            len_q   <= len_d;
`endif
        end
    end

    assign out_busy = busy_q;
    assign out_txen = txen_q;
    assign out_txd  = txd_q;
    assign out_txer = txer_q;

endmodule

// File: tb/tb_mac_tx.sv
// Directed bench for mac_tx: per-frame expected {txer,txd} bytes queued from a CRC model, popped while txen is high.
module tb_mac_tx;
    localparam int MINP = 46;
    localparam int MAXP = 1500;
    localparam int IPG  = 12;

    logic        in_txc = 1'b0;
    logic        in_rst_n = 1'b0;
    logic        in_start = 1'b0;
    logic [47:0] in_dest_mac = '0;
    logic [47:0] in_src_mac = '0;
    logic [15:0] in_ether_type = '0;
    logic [7:0]  in_data = '0;
    logic        in_data_valid = 1'b0;
    logic        in_data_last = 1'b0;
    logic        out_data_ready, out_busy, out_txen, out_txer;
    logic [7:0]  out_txd;

    always #5 in_txc = ~in_txc;

    mac_tx dut (
        .in_txc(in_txc), .in_rst_n(in_rst_n), .in_start(in_start),
        .in_dest_mac(in_dest_mac), .in_src_mac(in_src_mac), .in_ether_type(in_ether_type),
        .in_data(in_data), .in_data_valid(in_data_valid), .in_data_last(in_data_last),
        .out_data_ready(out_data_ready), .out_busy(out_busy), .out_txen(out_txen),
        .out_txd(out_txd), .out_txer(out_txer)
    );

    int          total = 0;
    int          bad = 0;
    logic [8:0]  exp_q[$];
    logic [7:0]  pay[0:1600];
    int          n_pay = 0;
    int          k = 0;
    int          underrun_at = -1;
    bit          send_last = 1'b1;
    int          txen_len = 0;
    int          pos = 0;
    logic [31:0] rx_crc = '1;
    int          len, gap;

    function automatic logic [31:0] crc8(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ b[i];
            r  = r >> 1;
            if (fb) r = r ^ 32'hEDB88320;
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                              input int n, input int ur, input bit over);
        logic [31:0] c;
        logic [7:0]  b;
        int          np;
        c = '1;
        for (int i = 0; i < 7; i++) exp_q.push_back({1'b0, 8'h55});
        exp_q.push_back({1'b0, 8'hD5});
        for (int i = 0; i < 6; i++) begin b = d[47-8*i -: 8]; exp_q.push_back({1'b0, b}); c = crc8(c, b); end
        for (int i = 0; i < 6; i++) begin b = s[47-8*i -: 8]; exp_q.push_back({1'b0, b}); c = crc8(c, b); end
        for (int i = 0; i < 2; i++) begin b = t[15-8*i -: 8]; exp_q.push_back({1'b0, b}); c = crc8(c, b); end
        if (ur >= 0) begin
            for (int i = 0; i < ur; i++) exp_q.push_back({1'b0, pay[i]});
            exp_q.push_back({1'b1, 8'h00});
        end else begin
            np = over ? MAXP : n;
            for (int i = 0; i < np; i++) begin exp_q.push_back({1'b0, pay[i]}); c = crc8(c, pay[i]); end
`ifdef MAC_TX_PAD_EN
            for (int i = np; i < MINP; i++) begin exp_q.push_back(9'h000); c = crc8(c, 8'h00); end
`endif
            c = ~c;
            for (int i = 0; i < 4; i++) begin b = c[8*i +: 8]; exp_q.push_back({over, b}); end
        end
    endtask

    task automatic cycle();
        logic       rdy;
        logic [8:0] e;
        rdy = out_data_ready;
        if (k < n_pay && k != underrun_at) begin
            in_data_valid = 1'b1;
            in_data       = pay[k];
            in_data_last  = send_last && (k == n_pay - 1);
        end else begin
            in_data_valid = 1'b0;
            in_data_last  = 1'b0;
        end
        @(posedge in_txc);
        #1;
        if (rdy && in_data_valid) k++;
        if (out_txen) begin
            txen_len++;
            pos++;
            if (pos > 8) rx_crc = crc8(rx_crc, out_txd);
            check("queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check($sformatf("byte%0d", pos), {23'd0, out_txer, out_txd}, {23'd0, e});
            end
        end
    endtask

    task automatic do_frame(input logic [47:0] d, input logic [47:0] s, input logic [15:0] t,
                            input int n, input bit lst, input int ur, input bit over, input bit hold);
        in_dest_mac = d; in_src_mac = s; in_ether_type = t;
        n_pay = n; k = 0; underrun_at = ur; send_last = lst;
        txen_len = 0; pos = 0; rx_crc = '1;
        push_frame(d, s, t, n, ur, over);
        in_start = 1'b1;
        cycle();
        in_start = hold;
    endtask

    task automatic wait_high(input string tag);
        int b = 0;
        while (!out_txen && b < 40) begin cycle(); b++; end
        check(tag, {31'd0, out_txen}, 32'd1);
    endtask

    task automatic wait_low(input string tag, output int l);
        int b = 0;
        while (out_txen && b < 2000) begin cycle(); b++; end
        check(tag, {31'd0, out_txen}, 32'd0);
        l = txen_len;
    endtask

    task automatic wait_idle(output int g);
        int b = 0;
        g = 1;
        while (out_busy && b < 40) begin cycle(); g++; b++; end
    endtask

    task automatic finish_frame(input string tag, input int exp_len);
        wait_high({tag, "_start"});
        wait_low({tag, "_end"}, len);
        check({tag, "_len"}, len, exp_len);
        wait_idle(gap);
        check({tag, "_ipg"}, gap, IPG);
        check({tag, "_queue_empty"}, exp_q.size(), 0);
    endtask

    initial begin
        for (int i = 0; i <= 1600; i++) pay[i] = 8'(i);

        // reset state
        in_rst_n = 1'b0;
        cycle(); cycle();
        check("rst_txen", {31'd0, out_txen}, 0);
        check("rst_txd", {24'd0, out_txd}, 0);
        check("rst_txer", {31'd0, out_txer}, 0);
        check("rst_busy", {31'd0, out_busy}, 0);
        check("rst_ready", {31'd0, out_data_ready}, 0);
        in_rst_n = 1'b1;
        cycle();

        // minimum frame
        do_frame(48'h0123456789AB, 48'h02AABBCCDDEE, 16'h0800, 46, 1, -1, 0, 0);
        wait_high("min_start");
        wait_low("min_end", len);
        check("min_len", len, 72);
        check("min_residue", rx_crc, 32'hDEBB20E3);
        wait_idle(gap);
        check("min_ipg", gap, IPG);
        check("min_queue_empty", exp_q.size(), 0);

        // short payload
        do_frame(48'hFFFFFFFFFFFF, 48'h001122334455, 16'h88B5, 10, 1, -1, 0, 0);
`ifdef MAC_TX_PAD_EN
        finish_frame("short", 72);
`else
        finish_frame("short", 36);
`endif
        check("short_residue", rx_crc, 32'hDEBB20E3);

        // underrun before payload byte 20
        do_frame(48'h0A0B0C0D0E0F, 48'h102030405060, 16'h86DD, 46, 1, 19, 0, 0);
        finish_frame("underrun", 22 + 19 + 1);

        // oversize
        do_frame(48'h0123456789AB, 48'h02AABBCCDDEE, 16'h0800, 1501, 0, -1, 1, 0);
        finish_frame("oversize", 1526);
        check("oversize_accepted", k, MAXP);
        n_pay = 0;

        // back-to-back with start held
        push_frame(48'h0123456789AB, 48'h02AABBCCDDEE, 16'h0800, 46, -1, 0);
        do_frame(48'h0123456789AB, 48'h02AABBCCDDEE, 16'h0800, 46, 1, -1, 0, 1);
        wait_high("b2b1_start");
        wait_low("b2b1_end", len);
        check("b2b1_len", len, 72);
        check("b2b1_residue", rx_crc, 32'hDEBB20E3);
        k = 0; txen_len = 0; pos = 0; rx_crc = '1;
        gap = 1;
        for (int b = 0; b < 40 && !out_txen; b++) begin cycle(); if (!out_txen) gap++; end
        // IPG_BYTES of gap, then one IDLE cycle to accept the held start
        check("b2b_gap", gap, IPG + 1);
        in_start = 1'b0;
        wait_low("b2b2_end", len);
        check("b2b2_len", len, 72);
        check("b2b2_residue", rx_crc, 32'hDEBB20E3);
        wait_idle(gap);
        check("b2b2_ipg", gap, IPG);
        check("b2b_queue_empty", exp_q.size(), 0);

        // reset mid-payload, then a clean frame
        do_frame(48'h0123456789AB, 48'h02AABBCCDDEE, 16'h0800, 46, 1, -1, 0, 0);
        for (int b = 0; b < 100 && k < 10; b++) cycle();
        check("midrst_reached", {31'd0, out_txen}, 1);
        in_rst_n = 1'b0;
        cycle();
        check("midrst_txen", {31'd0, out_txen}, 0);
        check("midrst_txd", {24'd0, out_txd}, 0);
        check("midrst_txer", {31'd0, out_txer}, 0);
        check("midrst_busy", {31'd0, out_busy}, 0);
        check("midrst_ready", {31'd0, out_data_ready}, 0);
        cycle();
        exp_q.delete();
        n_pay = 0;
        in_rst_n = 1'b1;
        for (int i = 0; i < 20; i++) cycle();
        check("midrst_quiet", {31'd0, out_txen | out_busy}, 0);
        do_frame(48'h0123456789AB, 48'h02AABBCCDDEE, 16'h0800, 46, 1, -1, 0, 0);
        finish_frame("after_rst", 72);
        check("after_rst_residue", rx_crc, 32'hDEBB20E3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
